// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge
//   Folds the core's instruction and data SRAM-like ports onto one AXI3
//   master. At most one read and one write are outstanding. Data reads win
//   over instruction reads. Data-port responses come back in request order
//   because a data read and a data write are never outstanding together.
//
// Ports
//   clk, resetn           : clock, synchronous active-low reset
//   inst_sram_*           : instruction port (reads only; wr/wstrb/wdata unused)
//   data_sram_*           : data port (reads and writes)
//   ar*/r*                : AXI read address / read data channels
//   aw*/w*/b*             : AXI write address / write data / write response
//   bridge_err            : sticky non-OKAY response flag
//
// Build option
//   BRIDGE_RESP_CHECK_EN  : when defined, bridge_err latches any non-OKAY
//                           rresp/bresp until reset; otherwise it is tied 0.
module sram_axi_bridge (
  input  logic        clk,
  input  logic        resetn,
  // instruction port
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  // data port
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  // AXI read address
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // AXI read data
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AXI write address
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  // AXI write data
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // AXI write response
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic        bridge_err
);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_R}  rstate_e;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_B} wstate_e;

  rstate_e     r_state_q;
  logic [31:0] ar_addr_q;
  logic [2:0]  ar_size_q;
  logic        ar_id_q;      // 1 = data port owns the read
  logic        arvalid_q, rready_q;

  wstate_e     w_state_q;
  logic [31:0] aw_addr_q, w_data_q;
  logic [2:0]  aw_size_q;
  logic [3:0]  w_strb_q;
  logic        awvalid_q, wvalid_q, bready_q;

  logic write_pending, data_rd_pending;
  logic data_rd_ok, data_wr_ok;
  logic inst_acc, data_rd_acc, data_wr_acc;
  logic r_fire, b_fire;
  logic aw_done, w_done;

  // ---------------- acceptance ----------------
  assign write_pending   = (w_state_q != W_IDLE);
  assign data_rd_pending = (r_state_q != R_IDLE) && ar_id_q;

  assign data_rd_ok = resetn && (r_state_q == R_IDLE) && !write_pending;
  // A data write may overlap an instruction read but not a data read.
  assign data_wr_ok = resetn && (w_state_q == W_IDLE) && !data_rd_pending;

  assign data_sram_addr_ok = data_sram_wr ? data_wr_ok : data_rd_ok;
  // Instruction read yields to a data read presented in the same cycle.
  assign inst_sram_addr_ok = resetn && (r_state_q == R_IDLE) &&
                             !(data_sram_req && !data_sram_wr);

  assign inst_acc    = inst_sram_req && inst_sram_addr_ok;
  assign data_rd_acc = data_sram_req && !data_sram_wr && data_rd_ok;
  assign data_wr_acc = data_sram_req &&  data_sram_wr && data_wr_ok;

  // ---------------- responses ----------------
  assign r_fire = resetn && (r_state_q == R_R) && rvalid;
  assign b_fire = resetn && (w_state_q == W_B) && bvalid;

  assign inst_sram_data_ok = r_fire && !rid[0];
  assign data_sram_data_ok = (r_fire && rid[0]) || b_fire;
  assign inst_sram_rdata   = rdata;
  assign data_sram_rdata   = rdata;

  // ---------------- read FSM ----------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state_q <= R_IDLE;
      ar_addr_q <= '0;
      ar_size_q <= '0;
      ar_id_q   <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (data_rd_acc) begin
            ar_addr_q <= data_sram_addr;
            ar_size_q <= {1'b0, data_sram_size};
            ar_id_q   <= 1'b1;
            arvalid_q <= 1'b1;
            r_state_q <= R_AR;
          end else if (inst_acc) begin
            ar_addr_q <= inst_sram_addr;
            ar_size_q <= {1'b0, inst_sram_size};
            ar_id_q   <= 1'b0;
            arvalid_q <= 1'b1;
            r_state_q <= R_AR;
          end
        end
        R_AR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            r_state_q <= R_R;
          end
        end
        R_R: begin
          if (rvalid) begin
            rready_q  <= 1'b0;
            r_state_q <= R_IDLE;
          end
        end
        default: begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
          r_state_q <= R_IDLE;
        end
      endcase
    end
  end

  // ---------------- write FSM ----------------
  // AW and W are issued together; each valid drops on its own handshake and
  // the cleared valid doubles as that channel's done flag.
  assign aw_done = !awvalid_q || awready;
  assign w_done  = !wvalid_q  || wready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      w_state_q <= W_IDLE;
      aw_addr_q <= '0;
      aw_size_q <= '0;
      w_strb_q  <= '0;
      w_data_q  <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (data_wr_acc) begin
            aw_addr_q <= data_sram_addr;
            aw_size_q <= {1'b0, data_sram_size};
            w_strb_q  <= data_sram_wstrb;
            w_data_q  <= data_sram_wdata;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            w_state_q <= W_REQ;
          end
        end
        W_REQ: begin
          if (awready) awvalid_q <= 1'b0;
          if (wready)  wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            bready_q  <= 1'b1;
            w_state_q <= W_B;
          end
        end
        W_B: begin
          if (bvalid) begin
            bready_q  <= 1'b0;
            w_state_q <= W_IDLE;
          end
        end
        default: begin
          awvalid_q <= 1'b0;
          wvalid_q  <= 1'b0;
          bready_q  <= 1'b0;
          w_state_q <= W_IDLE;
        end
      endcase
    end
  end

  // ---------------- AXI outputs ----------------
  assign arid    = {3'b000, ar_id_q};
  assign araddr  = ar_addr_q;
  assign arsize  = ar_size_q;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;
  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

  assign awid    = 4'd1;
  assign awaddr  = aw_addr_q;
  assign awsize  = aw_size_q;
  assign awvalid = awvalid_q;
  assign awlen   = 8'd0;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;

  assign wid     = 4'd1;
  assign wdata   = w_data_q;
  assign wstrb   = w_strb_q;
  assign wlast   = wvalid_q;   // single-beat bursts: every beat is last
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;

  // ---------------- response error flag ----------------
`ifdef BRIDGE_RESP_CHECK_EN
  logic err_q;
  logic err_d;

  assign err_d = err_q ||
                 (rvalid && rready_q && (rresp != 2'b00)) ||
                 (bvalid && bready_q && (bresp != 2'b00));

  always_ff @(posedge clk) begin
    if (!resetn) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign bridge_err = err_q;

  logic unused_sink;
  assign unused_sink = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                         rid[3:1], rlast, bid};
`else
  assign bridge_err = 1'b0;

  logic unused_sink;
  assign unused_sink = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                         rid[3:1], rlast, bid, rresp, bresp};
`endif

endmodule

// File: tb/tb_sram_axi_bridge.sv
module tb_sram_axi_bridge;
  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid, awid, wid, rid, bid, arcache, awcache, wstrb;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        bridge_err;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sram_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .bridge_err(bridge_err)
  );

  // Inputs are driven 1 ns after a rising edge; checks run 1 ns later,
  // so combinational outputs reflect the current cycle's inputs.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd2;
    inst_sram_wstrb = 0; inst_sram_addr = 0; inst_sram_wdata = 0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2;
    data_sram_wstrb = 0; data_sram_addr = 0; data_sram_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 0;
    inst_sram_req = 1; data_sram_req = 1; data_sram_wr = 1;
    tick(); tick(); #1;
    n_chk++; if (inst_sram_addr_ok !== 1'b0) begin n_fail++; $display("FAIL rst_inst_addr_ok got %0b want 0", inst_sram_addr_ok); end
    n_chk++; if (data_sram_addr_ok !== 1'b0) begin n_fail++; $display("FAIL rst_data_addr_ok got %0b want 0", data_sram_addr_ok); end
    n_chk++; if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b0) begin n_fail++; $display("FAIL rst_valids got %b want 00000", {arvalid, awvalid, wvalid, rready, bready}); end
    n_chk++; if ({inst_sram_data_ok, data_sram_data_ok, bridge_err} !== 3'b0) begin n_fail++; $display("FAIL rst_flags got %b want 000", {inst_sram_data_ok, data_sram_data_ok, bridge_err}); end
    n_chk++; if ({arlen, awlen, arburst, awburst, arlock, awlock, arcache, awcache, arprot, awprot} !== {8'd0, 8'd0, 2'b01, 2'b01, 2'b0, 2'b0, 4'd0, 4'd0, 3'd0, 3'd0}) begin n_fail++; $display("FAIL const_fields got wrong value %h", {arlen, awlen, arburst, awburst}); end
    idle_inputs();
    tick();
    resetn = 1;
    tick();
  endtask

  task automatic test_inst_read();
    inst_sram_req = 1; inst_sram_addr = 32'h1C000000; inst_sram_size = 2'd2;
    #1;
    n_chk++; if (inst_sram_addr_ok !== 1'b1) begin n_fail++; $display("FAIL ir_addr_ok got %0b want 1", inst_sram_addr_ok); end
    tick();
    inst_sram_req = 0; arready = 1; #1;
    n_chk++; if (arvalid !== 1'b1 || araddr !== 32'h1C000000) begin n_fail++; $display("FAIL ir_ar got v=%0b a=%h want v=1 a=1c000000", arvalid, araddr); end
    n_chk++; if (arid !== 4'd0 || arsize !== 3'b010) begin n_fail++; $display("FAIL ir_arid_size got %h/%h want 0/2", arid, arsize); end
    tick();
    arready = 0; rvalid = 1; rid = 0; rdata = 32'h02800C00; rlast = 1; #1;
    n_chk++; if (rready !== 1'b1 || inst_sram_data_ok !== 1'b1) begin n_fail++; $display("FAIL ir_data_ok got rr=%0b ok=%0b want 1/1", rready, inst_sram_data_ok); end
    n_chk++; if (inst_sram_rdata !== 32'h02800C00 || data_sram_data_ok !== 1'b0) begin n_fail++; $display("FAIL ir_rdata got %h dok=%0b want 02800c00/0", inst_sram_rdata, data_sram_data_ok); end
    tick();
    rvalid = 0; rlast = 0; #1;
    n_chk++; if ({arvalid, rready, inst_sram_data_ok} !== 3'b0) begin n_fail++; $display("FAIL ir_done got %b want 000", {arvalid, rready, inst_sram_data_ok}); end
  endtask

  task automatic test_priority();
    inst_sram_req = 1; inst_sram_addr = 32'h1C000004;
    data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h00001000; #1;
    n_chk++; if (data_sram_addr_ok !== 1'b1 || inst_sram_addr_ok !== 1'b0) begin n_fail++; $display("FAIL pri_addr_ok got d=%0b i=%0b want 1/0", data_sram_addr_ok, inst_sram_addr_ok); end
    tick();
    data_sram_req = 0; arready = 1; #1;
    n_chk++; if (arvalid !== 1'b1 || arid !== 4'd1 || araddr !== 32'h00001000) begin n_fail++; $display("FAIL pri_ar_data got v=%0b id=%h a=%h want 1/1/00001000", arvalid, arid, araddr); end
    n_chk++; if (inst_sram_addr_ok !== 1'b0) begin n_fail++; $display("FAIL pri_inst_wait got %0b want 0", inst_sram_addr_ok); end
    tick();
    arready = 0; rvalid = 1; rid = 4'd1; rdata = 32'h11112222; #1;
    n_chk++; if (data_sram_data_ok !== 1'b1 || data_sram_rdata !== 32'h11112222 || inst_sram_data_ok !== 1'b0) begin n_fail++; $display("FAIL pri_data_resp got ok=%0b d=%h iok=%0b want 1/11112222/0", data_sram_data_ok, data_sram_rdata, inst_sram_data_ok); end
    tick();
    rvalid = 0; #1;
    n_chk++; if (inst_sram_addr_ok !== 1'b1) begin n_fail++; $display("FAIL pri_inst_retry got %0b want 1", inst_sram_addr_ok); end
    tick();
    inst_sram_req = 0; arready = 1; #1;
    n_chk++; if (arvalid !== 1'b1 || arid !== 4'd0 || araddr !== 32'h1C000004) begin n_fail++; $display("FAIL pri_ar_inst got v=%0b id=%h a=%h want 1/0/1c000004", arvalid, arid, araddr); end
    tick();
    arready = 0; rvalid = 1; rid = 0; rdata = 32'h33334444; #1;
    n_chk++; if (inst_sram_data_ok !== 1'b1 || inst_sram_rdata !== 32'h33334444) begin n_fail++; $display("FAIL pri_inst_resp got ok=%0b d=%h want 1/33334444", inst_sram_data_ok, inst_sram_rdata); end
    tick();
    rvalid = 0;
  endtask

  task automatic test_write();
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h00002000;
    data_sram_wstrb = 4'b0011; data_sram_wdata = 32'h0000BEEF; data_sram_size = 2'd2; #1;
    n_chk++; if (data_sram_addr_ok !== 1'b1) begin n_fail++; $display("FAIL wr_addr_ok got %0b want 1", data_sram_addr_ok); end
    tick();
    data_sram_req = 0; awready = 1; #1;
    n_chk++; if ({awvalid, wvalid, wlast, bready} !== 4'b1110) begin n_fail++; $display("FAIL wr_issue got %b want 1110", {awvalid, wvalid, wlast, bready}); end
    n_chk++; if (awaddr !== 32'h00002000 || wdata !== 32'h0000BEEF || wstrb !== 4'b0011 || awid !== 4'd1 || wid !== 4'd1 || awsize !== 3'b010) begin n_fail++; $display("FAIL wr_fields got a=%h d=%h s=%b id=%h/%h sz=%h", awaddr, wdata, wstrb, awid, wid, awsize); end
    tick();
    awready = 0; #1;
    n_chk++; if ({awvalid, wvalid, bready} !== 3'b010) begin n_fail++; $display("FAIL wr_aw_drop got %b want 010", {awvalid, wvalid, bready}); end
    tick();
    wready = 1; #1;
    n_chk++; if ({wvalid, bready, data_sram_data_ok} !== 3'b100) begin n_fail++; $display("FAIL wr_w_hs got %b want 100", {wvalid, bready, data_sram_data_ok}); end
    tick();
    wready = 0; bvalid = 1; bid = 4'd1; #1;
    n_chk++; if ({wvalid, bready, data_sram_data_ok} !== 3'b011) begin n_fail++; $display("FAIL wr_b got %b want 011", {wvalid, bready, data_sram_data_ok}); end
    tick();
    bvalid = 0; #1;
    n_chk++; if ({bready, data_sram_data_ok} !== 2'b00) begin n_fail++; $display("FAIL wr_done got %b want 00", {bready, data_sram_data_ok}); end
  endtask

  task automatic test_write_then_read();
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h00002000;
    data_sram_wdata = 32'h12345678; data_sram_wstrb = 4'hF;
    tick();
    data_sram_wr = 0; awready = 1; wready = 1; #1;
    n_chk++; if (data_sram_addr_ok !== 1'b0) begin n_fail++; $display("FAIL wtr_block1 got %0b want 0", data_sram_addr_ok); end
    tick();
    awready = 0; wready = 0; #1;
    n_chk++; if (data_sram_addr_ok !== 1'b0 || bready !== 1'b1) begin n_fail++; $display("FAIL wtr_block2 got aok=%0b br=%0b want 0/1", data_sram_addr_ok, bready); end
    tick();
    bvalid = 1; #1;
    n_chk++; if (data_sram_data_ok !== 1'b1 || data_sram_addr_ok !== 1'b0) begin n_fail++; $display("FAIL wtr_bresp got ok=%0b aok=%0b want 1/0", data_sram_data_ok, data_sram_addr_ok); end
    tick();
    bvalid = 0; #1;
    n_chk++; if (data_sram_addr_ok !== 1'b1) begin n_fail++; $display("FAIL wtr_release got %0b want 1", data_sram_addr_ok); end
    tick();
    data_sram_req = 0; arready = 1; #1;
    n_chk++; if (arvalid !== 1'b1 || arid !== 4'd1 || araddr !== 32'h00002000) begin n_fail++; $display("FAIL wtr_ar got v=%0b id=%h a=%h want 1/1/00002000", arvalid, arid, araddr); end
    tick();
    arready = 0; rvalid = 1; rid = 4'd1; rdata = 32'h12345678; #1;
    n_chk++; if (data_sram_data_ok !== 1'b1 || data_sram_rdata !== 32'h12345678) begin n_fail++; $display("FAIL wtr_rd got ok=%0b d=%h want 1/12345678", data_sram_data_ok, data_sram_rdata); end
    tick();
    rvalid = 0;
  endtask

  task automatic test_overlap();
    inst_sram_req = 1; inst_sram_addr = 32'h1C000010;
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h00003000; #1;
    n_chk++; if (inst_sram_addr_ok !== 1'b1 || data_sram_addr_ok !== 1'b1) begin n_fail++; $display("FAIL ov_addr_ok got i=%0b d=%0b want 1/1", inst_sram_addr_ok, data_sram_addr_ok); end
    tick();
    inst_sram_req = 0; data_sram_req = 0; arready = 1; awready = 1; wready = 1; #1;
    n_chk++; if ({arvalid, awvalid, wvalid} !== 3'b111 || arid !== 4'd0) begin n_fail++; $display("FAIL ov_issue got %b id=%h want 111/0", {arvalid, awvalid, wvalid}, arid); end
    tick();
    arready = 0; awready = 0; wready = 0; rvalid = 1; rid = 0; bvalid = 1; #1;
    n_chk++; if (inst_sram_data_ok !== 1'b1 || data_sram_data_ok !== 1'b1) begin n_fail++; $display("FAIL ov_resp got i=%0b d=%0b want 1/1", inst_sram_data_ok, data_sram_data_ok); end
    tick();
    rvalid = 0; bvalid = 0;
  endtask

  task automatic test_reset_mid();
    inst_sram_req = 1; inst_sram_addr = 32'h1C000020;
    tick();
    inst_sram_req = 0; resetn = 0; #1;
    n_chk++; if (arvalid !== 1'b1) begin n_fail++; $display("FAIL rm_in_ar got %0b want 1", arvalid); end
    tick();
    resetn = 1; #1;
    n_chk++; if (arvalid !== 1'b0 || rready !== 1'b0) begin n_fail++; $display("FAIL rm_cleared got v=%0b rr=%0b want 0/0", arvalid, rready); end
    tick();
    rvalid = 1; rid = 0; rdata = 32'hDEADBEEF; #1;
    n_chk++; if (inst_sram_data_ok !== 1'b0 || data_sram_data_ok !== 1'b0) begin n_fail++; $display("FAIL rm_no_resp got i=%0b d=%0b want 0/0", inst_sram_data_ok, data_sram_data_ok); end
    tick();
    rvalid = 0;
    tick();
  endtask

  task automatic test_resp_err();
    logic exp_err;
`ifdef BRIDGE_RESP_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    for (int k = 0; k < 2; k++) begin
      data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h00004000 + k;
      tick();
      data_sram_req = 0; awready = 1; wready = 1;
      tick();
      awready = 0; wready = 0; bvalid = 1; bresp = (k == 0) ? 2'b10 : 2'b00;
      tick();
      bvalid = 0; bresp = 0; #1;
      n_chk++; if (bridge_err !== exp_err) begin n_fail++; $display("FAIL err_flag_%0d got %0b want %0b", k, bridge_err, exp_err); end
    end
  endtask

  initial begin
    test_reset();
    test_inst_read();
    test_priority();
    test_write();
    test_write_then_read();
    test_overlap();
    test_reset_mid();
    test_resp_err();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_axi_bridge.md
# sram_axi_bridge

Converts the core's two SRAM-like ports (instruction, data: req/addr_ok/data_ok) into a single AXI3 master. Sits directly downstream of the CPU core: the core's `inst_sram_*`/`data_sram_*` outputs drive its slave ports, and its AXI port goes to the memory interconnect.
- One read and one write in flight at a time.
- Data reads have priority over instruction reads.
- Data-port ordering is preserved.

## Interface
- Parameters: none.
- `clk` in 1: clock; all state on rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `inst_sram_req/wr/size/wstrb/addr/wdata` in 1/1/2/4/32/32: instruction request. `wr`, `wstrb`, `wdata` are ignored (reads only).
- `inst_sram_addr_ok`, `inst_sram_data_ok` out 1: request accepted; read data valid.
- `inst_sram_rdata` out 32: read data.
- `data_sram_req/wr/size/wstrb/addr/wdata` in 1/1/2/4/32/32: data request.
- `data_sram_addr_ok`, `data_sram_data_ok` out 1; `data_sram_rdata` out 32.
- `arid` out 4, `araddr` out 32, `arsize` out 3, `arvalid` out 1, `arready` in 1.
- `rid` in 4, `rdata` in 32, `rresp` in 2, `rlast` in 1, `rvalid` in 1, `rready` out 1.
- `awid` out 4, `awaddr` out 32, `awsize` out 3, `awvalid` out 1, `awready` in 1.
- `wid` out 4, `wdata` out 32, `wstrb` out 4, `wlast` out 1, `wvalid` out 1, `wready` in 1.
- `bid` in 4, `bresp` in 2, `bvalid` in 1, `bready` out 1.
- `arlen/awlen` out 8 = 0; `arburst/awburst` out 2 = 2'b01; `arlock/awlock` out 2 = 0; `arcache/awcache` out 4 = 0; `arprot/awprot` out 3 = 0. All constant.
- `bridge_err` out 1: sticky response-error flag (see Configuration).

## Operation
**Read FSM** (states R_IDLE, R_AR, R_R):
- `data_sram_addr_ok` for a read = R_IDLE & !write_pending.
- `inst_sram_addr_ok` = R_IDLE & !(data_sram_req & !data_sram_wr).
- On acceptance (req & addr_ok):
  - latch addr, `arsize = {1'b0,size}`, and `arid` (0 = inst, 1 = data);
  - go to R_AR.
- R_AR: `arvalid`=1 with latched fields held stable; `arvalid & arready` → R_R.
- R_R: `rready`=1.
  - On `rvalid` → R_IDLE.
  - Same cycle: `*_sram_data_ok` pulses combinationally on the port selected by `rid[0]`; `*_sram_rdata = rdata`.
- `rresp` does not alter the handshake.

**Write FSM** (states W_IDLE, W_REQ, W_B):
- `data_sram_addr_ok` for a write = W_IDLE & R_IDLE-or-inst-read-in-flight (no data read outstanding).
- On acceptance: latch addr, size, wstrb, wdata; go to W_REQ.
- W_REQ: `awvalid` and `wvalid` rise together.
  - Each drops independently after its own handshake (aw_done / w_done flags).
  - Both done → W_B.
- W_B: `bready`=1; on `bvalid` → W_IDLE and `data_sram_data_ok` pulses.
- `awid` = `wid` = 1; `wlast` = 1 whenever `wvalid`.

**Ordering**
- `write_pending` = W_REQ | W_B.
- A data read is never accepted while a write is pending; a data write is never accepted while a data read is pending.
- As a result, data-port `data_ok` returns in request order.
- An instruction read may overlap a data write.

## Timing
- Reset: FSMs idle, flags 0.
- Reset values: `arvalid`, `awvalid`, `wvalid`, `rready`, `bready`, both `addr_ok`, both `data_ok`, `bridge_err` = 0.
- `addr_ok` is forced 0 while `resetn` = 0.
- `addr_ok` is combinational in the request cycle.
- `arvalid`/`awvalid` rise the cycle after acceptance.
- Minimum read latency, req → `data_ok` = 2 cycles (`arready` in cycle 1, `rvalid` in cycle 2).
- Minimum write latency = 2 cycles.
- Simultaneous inst read + data read → data wins; inst is retried.
- Simultaneous inst read + data write → both accepted.
- Reset mid-transaction: all state discarded next edge; no response is delivered afterward.

## Configuration
- `BRIDGE_RESP_CHECK_EN` defined:
  - `bridge_err` sets on (`rvalid & rready & rresp != 0`) or (`bvalid & bready & bresp != 0`);
  - it stays set until reset.
- Not defined: `bridge_err` is tied 0 and no check logic is built.

## Test plan
- Inst read 0x1C000000, `arready` = 1, `rvalid` next cycle with 0x02800C00 → `araddr` 0x1C000000, `arid` 0, `inst_sram_data_ok` pulse with rdata 0x02800C00, 2 cycles after req.
- Inst and data reads in the same cycle (0x1C000004, 0x00001000) → data accepted first (`arid` 1); inst accepted the cycle R_IDLE returns.
- Data write 0x00002000, wstrb 4'b0011, data 0x0000BEEF, with `wready` two cycles after `awready` → `awvalid` drops first; `bready` asserted only after the W handshake; `data_ok` on `bvalid`.
- Data write pending, then data read 0x00002000 → read `addr_ok` held 0 until the B handshake; read issued afterward.
- Assert `resetn` = 0 while in R_AR → `arvalid` 0 next cycle; a later `rvalid` produces no `data_ok`.
- With `BRIDGE_RESP_CHECK_EN`, `bresp` = 2'b10 → `bridge_err` = 1 and stays 1 across later OKAY responses. Without the macro, `bridge_err` stays 0.
